// File: rtl/bus_mem_responder.sv
module bus_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        bus_err
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic          lat_we;
  logic [31:0]   mem [DEPTH];

  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic          cur_we;
  logic          cur_valid;
  logic [AW-1:0] cur_idx;
  logic          enter_resp;

  // With no wait states the response edge is also the accept edge, so the
  // live bus inputs are decoded directly instead of the latched copy.
  always_comb begin
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_we    = lat_we;
    if (state == ST_ACCEPT) begin
      cur_addr  = bus_addr;
      cur_wdata = bus_wdata;
      cur_we    = bus_we;
    end
    cur_idx    = cur_addr[AW+1:2];
    cur_valid  = (cur_addr[1:0] == 2'b00) && ({2'b00, cur_addr[31:2]} < 32'(DEPTH));
    enter_resp = ((state == ST_ACCEPT) && (WAIT_STATES == 0)) ||
                 ((state == ST_WAIT) && (wait_cnt == 4'd1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_ACCEPT;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_ready <= enter_resp;
      if (enter_resp) begin
        bus_rdata <= cur_valid ? mem[cur_idx] : '0;
        if (!cur_valid)
          bus_err <= 1'b1;
      end
      case (state)
        ST_ACCEPT: begin
          lat_addr  <= bus_addr;
          lat_wdata <= bus_wdata;
          lat_we    <= bus_we;
          wait_cnt  <= WAIT_LOAD;
          state     <= (WAIT_STATES != 0) ? ST_WAIT : ST_RESP;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1)
            state <= ST_RESP;
        end
        ST_RESP: state <= ST_ACCEPT;
        default: state <= ST_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur_we && cur_valid)
      mem[cur_idx] <= cur_wdata;
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: one instance with no wait states and
// one with three, each checked by its own monitor against queued expectations.
module tb_bus_mem_responder;

   typedef struct {
      logic [31:0] data;
      logic        chk_data;
      logic        err;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        a_reset = 1'b1, b_reset = 1'b1;
   logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
   logic        a_we = 1'b0, b_we = 1'b0;
   logic [31:0] a_rdata, b_rdata;
   logic        a_ready, b_ready, a_err, b_err;

   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   logic        a_prev = 1'b0, b_prev = 1'b0;

   bus_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_a (
      .clk(clk), .reset(a_reset), .bus_addr(a_addr), .bus_wdata(a_wdata),
      .bus_we(a_we), .bus_rdata(a_rdata), .bus_ready(a_ready), .bus_err(a_err));

   bus_mem_responder #(.DEPTH(1024), .WAIT_STATES(3)) u_b (
      .clk(clk), .reset(b_reset), .bus_addr(b_addr), .bus_wdata(b_wdata),
      .bus_we(b_we), .bus_rdata(b_rdata), .bus_ready(b_ready), .bus_err(b_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic monitor_step(input string tag, input logic rst, input logic rdy,
                               input logic [31:0] rdata, input logic err,
                               inout exp_t q[$], inout logic prev);
      exp_t e;
      if (!rst) begin
         if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            check({tag, "_ready_timeout"}, 32'(cyc), 32'(e.cyc));
         end
         if (rdy) begin
            check({tag, "_ready_back_to_back"}, 32'(prev), 32'd0);
            if (q.size() == 0) begin
               check({tag, "_unexpected_ready"}, 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check({tag, "_ready_cycle"}, 32'(cyc), 32'(e.cyc));
               if (e.chk_data)
                  check({tag, "_rdata"}, rdata, e.data);
               check({tag, "_err"}, 32'(err), 32'(e.err));
            end
         end
      end
      prev = rdy;
   endtask

   always @(negedge clk) monitor_step("a", a_reset, a_ready, a_rdata, a_err, qa, a_prev);
   always @(negedge clk) monitor_step("b", b_reset, b_ready, b_rdata, b_err, qb, b_prev);

   // Called at the negedge of an ACCEPT cycle; returns at the negedge of the next one.
   task automatic xfer(input bit sel_b, input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic chk, input logic exp_err);
      exp_t e;
      int unsigned ws;
      ws = sel_b ? 3 : 0;
      e.data = exp_data; e.chk_data = chk; e.err = exp_err; e.cyc = cyc + 1 + ws;
      if (sel_b) begin
         b_addr = addr; b_we = we; b_wdata = wdata; qb.push_back(e);
      end else begin
         a_addr = addr; a_we = we; a_wdata = wdata; qa.push_back(e);
      end
      repeat (2 + ws) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("a_reset_ready", 32'(a_ready), 32'd0);
      check("a_reset_rdata", a_rdata, 32'h0);
      check("a_reset_err", 32'(a_err), 32'd0);
      check("b_reset_ready", 32'(b_ready), 32'd0);
      check("b_reset_rdata", b_rdata, 32'h0);
      check("b_reset_err", 32'(b_err), 32'd0);

      // Instance A, no wait states
      a_reset = 1'b0;
      xfer(0, 32'h0000_0000, 1, 32'h0050_0093, 32'h0, 0, 0);
      xfer(0, 32'h0000_0FFC, 1, 32'hDEAD_BEEF, 32'h0, 0, 0);
      xfer(0, 32'h0000_0FFC, 0, 32'h0, 32'hDEAD_BEEF, 1, 0);
      a_reset = 1'b1;
      #1;
      check("a_async_clear_rdata", a_rdata, 32'h0);
      check("a_async_clear_ready", 32'(a_ready), 32'd0);
      repeat (2) @(negedge clk);
      a_reset = 1'b0;
      xfer(0, 32'h0000_0000, 0, 32'h0, 32'h0050_0093, 1, 0);
      xfer(0, 32'h0000_0000, 0, 32'h0, 32'h0050_0093, 1, 0);
      xfer(0, 32'h0000_1000, 1, 32'h0000_0001, 32'h0, 1, 1);
      xfer(0, 32'h0000_0000, 0, 32'h0, 32'h0050_0093, 1, 1);
      a_reset = 1'b1;
      #1;
      check("a_err_cleared_by_reset", 32'(a_err), 32'd0);
      repeat (2) @(negedge clk);
      a_reset = 1'b0;
      xfer(0, 32'h0000_0006, 0, 32'h0, 32'h0, 1, 1);
      xfer(0, 32'h0000_0002, 1, 32'hFFFF_FFFF, 32'h0, 1, 1);
      xfer(0, 32'h0000_0000, 0, 32'h0, 32'h0050_0093, 1, 1);
      a_reset = 1'b1;
      #1;
      check("a_err_cleared_again", 32'(a_err), 32'd0);

      // Instance B, three wait states
      @(negedge clk);
      b_reset = 1'b0;
      xfer(1, 32'h0000_0010, 1, 32'h1111_1111, 32'h0, 0, 0);
      xfer(1, 32'h0000_0010, 1, 32'hCAFE_F00D, 32'h1111_1111, 1, 0);
      xfer(1, 32'h0000_0010, 0, 32'h0, 32'hCAFE_F00D, 1, 0);
      xfer(1, 32'h0000_0004, 1, 32'hA4A4_A4A4, 32'h0, 0, 0);
      xfer(1, 32'h0000_0008, 1, 32'hB8B8_B8B8, 32'h0, 0, 0);
      begin
         exp_t e;
         e.data = 32'hA4A4_A4A4; e.chk_data = 1'b1; e.err = 1'b0; e.cyc = cyc + 4;
         b_addr = 32'h4; b_we = 1'b0; b_wdata = 32'h0; qb.push_back(e);
         @(negedge clk);
         b_addr = 32'h8; b_we = 1'b1; b_wdata = 32'h0BAD_0BAD;
         repeat (4) @(negedge clk);
      end
      xfer(1, 32'h0000_0008, 0, 32'h0, 32'hB8B8_B8B8, 1, 0);
      xfer(1, 32'h0000_0020, 1, 32'h0000_1234, 32'h0, 0, 0);
      xfer(1, 32'h0000_0020, 0, 32'h0, 32'h0000_1234, 1, 0);
      b_addr = 32'h20; b_we = 1'b1; b_wdata = 32'h0000_0055;
      repeat (2) @(negedge clk);
      b_reset = 1'b1;
      #1;
      check("b_midwait_reset_ready", 32'(b_ready), 32'd0);
      check("b_midwait_reset_rdata", b_rdata, 32'h0);
      repeat (2) @(negedge clk);
      b_reset = 1'b0;
      xfer(1, 32'h0000_0020, 0, 32'h0, 32'h0000_1234, 1, 0);
      b_reset = 1'b1;

      repeat (3) @(negedge clk);
      check("a_queue_drained", 32'(qa.size()), 32'd0);
      check("b_queue_drained", 32'(qb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
